compy_bus_arbiter: RTL
======================

# compy_bus_arbiter

Parametrised N-master to single-memory-port arbiter for the compy system bus. It replaces the hard-wired chroni-only read path with a generalised request/acknowledge fabric. Chroni video fetch, the CPU and future DMA masters share one SDRAM/ROM access port, with fixed-priority or round-robin arbitration, read and write support, and a per-access timeout.

## Interface
- NUM_MASTERS, 2, number of requesting masters (1..8); master 0 is chroni by convention
- ADDR_WIDTH, 19, memory address width (matches the SDRAM bus address)
- DATA_WIDTH, 16, data width of the master and memory data buses
- RR_MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before aborting; 0 disables the timeout

Ports (clock and reset first):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_req  in  NUM_MASTERS  per-master request; held high until that master's m_ack
- m_we  in  NUM_MASTERS  per-master write enable; 1 = write, 0 = read
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  flattened write data, same slicing scheme as m_addr
- m_ack  out  NUM_MASTERS  one-cycle completion pulse to the granted master
- m_err  out  NUM_MASTERS  one-cycle pulse coincident with m_ack when the access timed out
- m_rdata  out  DATA_WIDTH  shared read data; valid only in the m_ack cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completion; must be high for at least one cycle
- mem_rdata  in  DATA_WIDTH  memory read data; sampled in the mem_ack cycle
- busy  out  1  high whenever the state is not IDLE
- grant_idx  out  max(1,$clog2(NUM_MASTERS))  index of the current or last granted master

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE, when any m_req bit is set:
  - pick the winner;
  - latch the winner's we, addr and wdata into mem_* registers;
  - set mem_req = 1 and clear the timeout counter;
  - go to ACCESS.
- Winner selection:
  - RR_MODE = 0: lowest set index.
  - RR_MODE = 1: first set index scanning from (grant_idx+1) mod NUM_MASTERS upward with wrap.
- ACCESS, on mem_ack:
  - register m_rdata <= mem_rdata (reads only; writes leave m_rdata unchanged);
  - set mem_req = 0;
  - go to RESP.
- ACCESS, timeout when the counter reaches TIMEOUT_CYCLES without mem_ack:
  - set m_rdata = all ones and mem_req = 0;
  - flag the error;
  - go to RESP.
- RESP:
  - pulse m_ack[grant_idx] for one cycle, plus m_err[grant_idx] if the access timed out;
  - return to IDLE.
- Requests are latched at grant. A master dropping m_req during ACCESS does not cancel the access; its ack still pulses.
- A master keeping m_req high in the cycle after its ack is treated as a new request and competes normally in that IDLE cycle.
- mem_ack arriving while not in ACCESS is ignored.
- mem_ack and timeout in the same cycle: mem_ack wins and no error is raised.
- Reset values (asynchronous, including mid-access): every output is 0, grant_idx = NUM_MASTERS-1 so that master 0 wins first under round-robin, and state = IDLE. mem_req drops immediately on reset; no ack is issued for the aborted access.

## Timing
- Request high at edge 0 (IDLE) → mem_req high after edge 1.
- mem_ack sampled high at edge k → RESP after edge k+1 → m_ack high for cycle k+1..k+2.
- Minimum latency, m_req to m_ack: 3 edges (memory acks in the first ACCESS cycle).
- Throughput: one access per 3 + memory-wait cycles. IDLE always lasts at least one cycle between accesses.
- Timeout: m_ack with error occurs TIMEOUT_CYCLES+2 edges after grant.
- mem_addr, mem_we and mem_wdata are stable from grant until the cycle after mem_ack.

## Test plan
- Single read: master 1 reads addr 0x1234; memory acks 2 cycles later with 0xBEEF → m_ack[1] pulses once, m_rdata = 0xBEEF, m_err = 0, total latency 5 edges.
- Fixed priority: RR_MODE = 0, m_req = 2'b11 held for 4 accesses → all 4 grants go to master 0; master 1 is starved.
- Round-robin: RR_MODE = 1, NUM_MASTERS = 4, all requesting continuously → grant order 0,1,2,3,0,1; no master waits more than 3 accesses.
- Write: master 0 writes 0x00AA to 0x0200 → mem_we = 1, mem_addr = 0x0200, mem_wdata = 0x00AA stable until mem_ack; m_rdata unchanged.
- Timeout: TIMEOUT_CYCLES = 8, mem_ack never asserted → m_ack and m_err pulse together at grant+10 edges, m_rdata = 0xFFFF, next request is serviced normally.
- Reset mid-access: assert reset during ACCESS → mem_req, busy and m_ack go to 0 immediately; after release, the pending master is re-granted from IDLE.

Source files
------------

// File: rtl/compy_bus_arbiter_if.sv
// Bus bundle between the compy masters, the arbiter and the shared memory port.
// The slave modport is the arbiter's view; the master modport is the opposite side.
interface compy_bus_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 2,
   parameter int unsigned ADDR_WIDTH  = 19,
   parameter int unsigned DATA_WIDTH  = 16
);
   localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [NUM_MASTERS-1:0]            m_req;
   logic [NUM_MASTERS-1:0]            m_we;
   logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
   logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
   logic [NUM_MASTERS-1:0]            m_ack;
   logic [NUM_MASTERS-1:0]            m_err;
   logic [DATA_WIDTH-1:0]             m_rdata;
   logic                              mem_req;
   logic                              mem_we;
   logic [ADDR_WIDTH-1:0]             mem_addr;
   logic [DATA_WIDTH-1:0]             mem_wdata;
   logic                              mem_ack;
   logic [DATA_WIDTH-1:0]             mem_rdata;
   logic                              busy;
   logic [GW-1:0]                     grant_idx;

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, mem_ack, mem_rdata,
      output m_ack, m_err, m_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, grant_idx
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata, mem_ack, mem_rdata,
      input  m_ack, m_err, m_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, grant_idx
   );
endinterface

// File: rtl/compy_bus_arbiter.sv
// N-master arbiter onto one memory port: fixed-priority or round-robin grant,
// read/write, per-access timeout that returns all-ones data with an error pulse.
module compy_bus_arbiter #(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned ADDR_WIDTH     = 19,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned RR_MODE        = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                clk,
   input logic                reset,
   compy_bus_arbiter_if.slave bus
);
   localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                r_state, w_next;
   logic [GW-1:0]         r_grant;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [CW-1:0]         r_cnt;
   logic                  r_err;

   logic                   w_any;
   logic [GW-1:0]          w_cand;
   logic [GW-1:0]          w_winner;
   logic                   w_sel_we;
   logic [ADDR_WIDTH-1:0]  w_sel_addr;
   logic [DATA_WIDTH-1:0]  w_sel_wdata;
   logic                   w_timeout;
   logic [NUM_MASTERS-1:0] w_ack;
   logic [NUM_MASTERS-1:0] w_err;

   // Scan candidates in priority order; round-robin starts just after the last grant.
   always_comb begin
      w_any    = 1'b0;
      w_cand   = '0;
      w_winner = r_grant;
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
         w_cand = (RR_MODE != 0) ? GW'((32'(r_grant) + 1 + k) % NUM_MASTERS) : GW'(k);
         for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!w_any && (w_cand == GW'(i)) && bus.m_req[i]) begin
               w_any    = 1'b1;
               w_winner = w_cand;
            end
         end
      end
   end

   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (w_winner == GW'(i)) begin
            w_sel_we    = bus.m_we[i];
            w_sel_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_sel_wdata = bus.m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_ack  = '0;
      w_err  = '0;
      case (r_state)
         IDLE:    if (w_any) w_next = ACCESS;
         ACCESS:  if (bus.mem_ack || w_timeout) w_next = RESP;
         RESP: begin
            w_next = IDLE;
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
               if (r_grant == GW'(i)) begin
                  w_ack[i] = 1'b1;
                  w_err[i] = r_err;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_grant     <= GW'(NUM_MASTERS - 1);
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_grant     <= w_winner;
               r_mem_req   <= 1'b1;
               r_mem_we    <= w_sel_we;
               r_mem_addr  <= w_sel_addr;
               r_mem_wdata <= w_sel_wdata;
               r_cnt       <= '0;
               r_err       <= 1'b0;
            end
            // mem_ack takes precedence over an expiring timeout
            ACCESS: if (bus.mem_ack) begin
               if (!r_mem_we) r_rdata <= bus.mem_rdata;
               r_mem_req <= 1'b0;
            end else if (w_timeout) begin
               r_rdata   <= '1;
               r_mem_req <= 1'b0;
               r_err     <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.m_ack     = w_ack;
   assign bus.m_err     = w_err;
   assign bus.m_rdata   = r_rdata;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.busy      = (r_state != IDLE);
   assign bus.grant_idx = r_grant;
endmodule
